// File: rtl/fpu_mul_unit_if.sv
// Handshake/operand bundle between the FPU main controller and fpu_mul_unit.
// The controller drives the master side; the multiplier exposes the slave side.
interface fpu_mul_unit_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        ack;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, a, b, ack,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b, ack,
    output busy, done, result
  );
endinterface

// File: rtl/fpu_mul_unit.sv
// Sequential binary32 multiplier: shift-add significand product, normalize, specials, held result.
// Define FPU_MUL_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fpu_mul_unit (
  input logic           clk,
  input logic           arst,
  fpu_mul_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADD,
    S_SHIFT,
    S_RESULT_SET,
    S_END
  } state_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sign_q, sign_d;
  logic        special_q, special_d;
  logic [31:0] special_res_q, special_res_d;
  logic [23:0] mcand_q, mcand_d;
  logic [23:0] mplier_q, mplier_d;
  logic [47:0] prod_q, prod_d;
  logic        carry_q, carry_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;

  // Operand classification; denormals (exp == 0) count as zero.
  logic [7:0] ea, eb;
  logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic       op_sign, is_special;
  logic [31:0] special_val;

  assign ea     = a_q[30:23];
  assign eb     = b_q[30:23];
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
  assign op_sign = a_q[31] ^ b_q[31];

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    is_special  = 1'b1;
    special_val = {op_sign, 31'd0};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      special_val = QNAN;
    end else if (a_inf || b_inf) begin
      special_val = {op_sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      special_val = {op_sign, 31'd0};
    end else begin
      is_special = 1'b0;
    end
  end

  // Normalization: a set bit47 means the product is in [2,4) and needs one more exponent step.
  logic               norm_hi;
  logic [22:0]        mant_raw;
  logic [23:0]        mant_rnd;
  logic signed [9:0]  exp_base, exp_norm, exp_fin;
  logic               round_up;
  logic [31:0]        packed_res;

  assign norm_hi  = prod_q[47];
  assign mant_raw = norm_hi ? prod_q[46:24] : prod_q[45:23];
  assign exp_base = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
  assign exp_norm = exp_base + (norm_hi ? 10'sd1 : 10'sd0);

`ifdef FPU_MUL_RNE_EN
  logic guard_bit, sticky_bit;
  assign guard_bit  = norm_hi ? prod_q[23] : prod_q[22];
  assign sticky_bit = norm_hi ? (|prod_q[22:0]) : (|prod_q[21:0]);
  assign round_up   = guard_bit & (sticky_bit | mant_raw[0]);
`else
  logic unused_low_bits;
  assign unused_low_bits = ^prod_q[22:0];
  assign round_up        = 1'b0;
`endif

  // A rounding carry-out leaves the mantissa field at zero and bumps the exponent.
  assign mant_rnd = {1'b0, mant_raw} + {23'd0, round_up};
  assign exp_fin  = exp_norm + (mant_rnd[23] ? 10'sd1 : 10'sd0);

  always_comb begin
    packed_res = {sign_q, exp_fin[7:0], mant_rnd[22:0]};
    if (exp_fin >= 10'sd255) begin
      packed_res = {sign_q, 8'hFF, 23'd0};
    end else if (exp_fin <= 10'sd0) begin
      packed_res = {sign_q, 31'd0};
    end
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    sign_d        = sign_q;
    special_d     = special_q;
    special_res_d = special_res_q;
    mcand_d       = mcand_q;
    mplier_d      = mplier_q;
    prod_d        = prod_q;
    carry_d       = carry_q;
    cnt_d         = cnt_q;
    result_d      = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = S_START;
        end
      end

      S_START: begin
        sign_d        = op_sign;
        special_d     = is_special;
        special_res_d = special_val;
        if (is_special) begin
          state_d = S_RESULT_SET;
        end else begin
          prod_d   = 48'd0;
          carry_d  = 1'b0;
          mcand_d  = {1'b1, a_q[22:0]};
          mplier_d = {1'b1, b_q[22:0]};
          cnt_d    = 5'd23;
          state_d  = S_ADD;
        end
      end

      S_ADD: begin
        if (mplier_q[0]) begin
          {carry_d, prod_d[47:24]} = {1'b0, prod_q[47:24]} + {1'b0, mcand_q};
        end
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        {carry_d, prod_d} = {1'b0, carry_q, prod_q[47:1]};
        mplier_d          = mplier_q >> 1;
        if (cnt_q == 5'd0) begin
          state_d = S_RESULT_SET;
        end else begin
          cnt_d   = cnt_q - 5'd1;
          state_d = S_ADD;
        end
      end

      S_RESULT_SET: begin
        result_d = special_q ? special_res_q : packed_res;
        state_d  = S_END;
      end

      S_END: begin
        // A coincident start is ignored here; a relaunch needs start again in IDLE.
        if (bus.ack) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // NOTE: the datapath is a handful of flops (no memory arrays), so all of it is reset to known zeros.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      a_q           <= 32'd0;
      b_q           <= 32'd0;
      sign_q        <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= 32'd0;
      mcand_q       <= 24'd0;
      mplier_q      <= 24'd0;
      prod_q        <= 48'd0;
      carry_q       <= 1'b0;
      cnt_q         <= 5'd0;
      result_q      <= 32'd0;
    end else begin
      a_q           <= a_d;
      b_q           <= b_d;
      sign_q        <= sign_d;
      special_q     <= special_d;
      special_res_q <= special_res_d;
      mcand_q       <= mcand_d;
      mplier_q      <= mplier_d;
      prod_q        <= prod_d;
      carry_q       <= carry_d;
      cnt_q         <= cnt_d;
      result_q      <= result_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_END);
  assign bus.result = result_q;

endmodule

// File: tb/tb_fpu_mul_unit.sv
// Directed bench for fpu_mul_unit: products, specials, range limits, handshake and reset.
// Expected rounding result follows FPU_MUL_RNE_EN when the bench is built with it.
module tb_fpu_mul_unit;

  logic clk;
  logic arst;
  int   vectors;
  int   miscompares;

  fpu_mul_unit_if bus ();

  fpu_mul_unit dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge (edge 0), then scramble the operand bus.
  task automatic launch(input logic [31:0] op_a, input logic [31:0] op_b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = op_a;
    bus.b     = op_b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~op_a;
    bus.b     = 32'hDEAD_BEEF;
  endtask

  // Count edges after edge 0 until done; elapsed is how many already passed.
  task automatic wait_done(input string tag, input int elapsed, input int exp_lat);
    int n;
    n = elapsed;
    while (!bus.done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic do_ack(input string tag);
    bus.ack = 1'b1;
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
    check({tag, " busy after ack"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                    input logic [31:0] exp_res, input int exp_lat);
    launch(op_a, op_b);
    wait_done(tag, 0, exp_lat);
    check({tag, " result"}, bus.result, exp_res);
    do_ack(tag);
  endtask

  logic [31:0] exp_round;

  initial begin
    vectors     = 0;
    miscompares = 0;
    arst        = 1'b0;
    bus.start   = 1'b0;
    bus.a       = 32'd0;
    bus.b       = 32'd0;
    bus.ack     = 1'b0;
`ifdef FPU_MUL_RNE_EN
    exp_round = 32'h4010_0002;
`else
    exp_round = 32'h4010_0001;
`endif

    #12;
    check("reset busy",   {31'd0, bus.busy}, 32'd0);
    check("reset done",   {31'd0, bus.done}, 32'd0);
    check("reset result", bus.result,        32'd0);
    @(negedge clk);
    arst = 1'b1;

    // Basic product with busy/done checked right after edge 0.
    launch(32'h4000_0000, 32'h4040_0000);
    check("busy after start", {31'd0, bus.busy}, 32'd1);
    check("done after start", {31'd0, bus.done}, 32'd0);
    wait_done("2x3", 0, 50);
    check("2x3 result", bus.result, 32'h40C0_0000);
    do_ack("2x3");

    op("1.5x1.5",   32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 50);
    op("round",     32'h3FC0_0001, 32'h3FC0_0001, exp_round,     50);
    op("-1x1",      32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, 50);
    op("inf x 0",   32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 2);
    op("-2 x 0",    32'hC000_0000, 32'h0000_0000, 32'h8000_0000, 2);
    op("nan x 1",   32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 2);
    op("-inf x 2",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 2);
    op("denorm x2", 32'h0000_0001, 32'h4000_0000, 32'h0000_0000, 2);
    op("overflow",  32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 50);
    op("underflow", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 50);

    // Ack pulsed mid-computation is ignored; then done/result hold while ack stays low.
    launch(32'h4000_0000, 32'h4040_0000);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.ack = 1'b1;
    @(posedge clk);
    #1;
    bus.ack = 1'b0;
    wait_done("early ack", 10, 50);
    check("early ack result", bus.result, 32'h40C0_0000);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("hold done",   {31'd0, bus.done}, 32'd1);
      check("hold result", bus.result,        32'h40C0_0000);
    end

    // start together with ack in END returns to IDLE without relaunching.
    bus.start = 1'b1;
    bus.a     = 32'h3FC0_0000;
    bus.b     = 32'h3FC0_0000;
    bus.ack   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    check("start+ack busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1;
    check("no relaunch busy",   {31'd0, bus.busy}, 32'd0);
    check("no relaunch done",   {31'd0, bus.done}, 32'd0);
    check("no relaunch result", bus.result,        32'h40C0_0000);

    // Asynchronous reset in the middle of an operation, then a clean rerun.
    launch(32'h3FC0_0000, 32'h3FC0_0000);
    repeat (24) begin
      @(posedge clk);
      #1;
    end
    #2;
    arst = 1'b0;
    #1;
    check("arst busy",   {31'd0, bus.busy}, 32'd0);
    check("arst done",   {31'd0, bus.done}, 32'd0);
    check("arst result", bus.result,        32'd0);
    @(negedge clk);
    arst = 1'b1;
    op("after arst", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_mul_unit.md
# fpu_mul_unit

Sequential IEEE-754 single-precision multiplier for the Sol-1 FPU. The FPU main controller launches it for `op_mul` and `op_square` and waits in its multiply-wait state until the unit raises `done`. The unit computes the 24×24 significand product with a shift-add loop, one product step per state. It then normalizes the result, handles special operands, and holds the packed result until the controller acknowledges it.

## Interface
Parameters:
- none; the format is fixed at binary32.

Ports:
- `clk`  in  1  system clock, rising edge.
- `arst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  launch request; sampled only in IDLE.
- `a`  in  32  operand A; captured on the start edge.
- `b`  in  32  operand B; captured on the start edge.
- `ack`  in  1  controller has consumed the result.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  result valid; high only in END.
- `result`  out  32  packed product; stable while `done` is high.

## Operation
State machine: IDLE → START → (ADD ↔ SHIFT) ×24 → RESULT_SET → END → IDLE.
- IDLE: on `start`=1, register `a` and `b`, go to START.
- START: unpack the operands.
  - sign = sa ^ sb.
  - Denormal inputs (exp=0) are flushed to zero.
  - Special operands set a result and go straight to RESULT_SET:
    - NaN operand, or inf×0: result 0x7FC00000.
    - inf × finite nonzero: signed inf.
    - zero operand: signed zero.
  - Otherwise: clear the 48-bit product, load 24-bit significands with the hidden 1, load the 5-bit counter with 23, go to ADD.
- ADD: if multiplier bit0=1, add the multiplicand into the product's upper 25 bits (carry kept). Go to SHIFT.
- SHIFT: shift the {carry, product} pair right 1 and shift the multiplier right 1.
  - counter=0 → RESULT_SET.
  - otherwise decrement the counter and go to ADD.
- RESULT_SET (normal path):
  - Exponent is 10-bit signed: e = ea + eb − 127.
  - If product bit47=1, take the significand from [46:24] and set e+1. Otherwise take it from [45:23].
  - Round (see Configuration); a mantissa carry-out increments e.
  - e ≥ 255 → signed inf.
  - e ≤ 0 → signed zero (no denormal output).
- END: `done`=1 and `result` held. On `ack`=1 → IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0x00000000, state IDLE, all datapath registers 0.
- Edge numbering: edge 0 is the edge that samples `start`.
- Normal path:
  - START occupies the cycle after edge 0.
  - 48 ADD/SHIFT cycles follow.
  - RESULT_SET is entered at edge 49.
  - END is entered at edge 50, so `done` rises 50 cycles after the start edge.
- Special path: RESULT_SET at edge 1, END at edge 2.
- `busy` rises the cycle after edge 0 and falls the cycle after `ack` is sampled in END.
- `done` stays high indefinitely until `ack`. An `ack` outside END is ignored.
- `start` while `busy`=1 is ignored, including when `start` and `ack` arrive together in END. That edge returns the unit to IDLE only; a new start needs `start` high again in IDLE.
- Operand changes after edge 0 have no effect.
- `arst` low at any time: immediate return to IDLE with all outputs at reset values. The in-flight operation is lost.

## Configuration
- `FPU_MUL_RNE_EN` defined: round-to-nearest-even.
  - Uses guard bit = first dropped bit and sticky = OR of the remaining dropped bits.
  - Round up when guard & (sticky | lsb).
- Not defined: truncation (round toward zero). The guard/sticky logic is not built.
- Latency is identical in both builds.

## Test plan
- Basic product: 0x40000000 × 0x40400000, start pulse → `done` 50 cycles after the start edge, `result`=0x40C00000 (6.0).
- Normalization: 0x3FC00000 × 0x3FC00000 → 0x40100000 (2.25), exponent bumped by bit47.
- Rounding: 0x3FC00001 × 0x3FC00001 → 0x40100001 without the macro, 0x40100002 with `FPU_MUL_RNE_EN`.
- Specials: 0x7F800000 × 0x00000000 → 0x7FC00000 with `done` 2 cycles after start; 0xC0000000 × 0x00000000 → 0x80000000.
- Range limits:
  - 0x7F7FFFFF × 0x40000000 → 0x7F800000.
  - 0x00800000 × 0x00800000 → 0x00000000.
- Handshake and reset:
  - Hold `ack`=0 for 20 cycles → `done` and `result` stable.
  - `start`+`ack` together in END → IDLE with no relaunch.
  - `arst` low at cycle 25 of an operation → `busy`/`done`/`result` 0 immediately, and a fresh start then completes correctly.
